// File: rtl/cla_nibble_sequencer_if.sv
// Bundle between calculator control, the sequencer and the shared 4-bit CLA slice.
// The master side is the calculator plus the slice; the slave side is the sequencer.
interface cla_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             add_en;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [4:0]       add_q;

  modport master (
    output start, sub, cin, op_a, op_b, add_q,
    input  busy, done, result, cout, overflow, add_en, add_a, add_b, add_cin
  );

  modport slave (
    input  start, sub, cin, op_a, op_b, add_q,
    output busy, done, result, cout, overflow, add_en, add_a, add_b, add_cin
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Drives one registered 4-bit CLA slice over WIDTH/4 passes, LSB nibble first,
// chaining the carry through Q[4], to add or subtract WIDTH-bit operands.
module cla_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  cla_nibble_sequencer_if.slave bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_DONE
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             carry_q,    carry_d;
  logic [IW-1:0]    idx_q,      idx_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;
  logic [3:0]       add_a_q,    add_a_d;
  logic [3:0]       add_b_q,    add_b_d;
  logic             add_cin_q,  add_cin_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
    end
  end

  // The slice inputs are loaded on the edge that enters ISSUE, so the first
  // nibble comes straight from the ports and later ones from the latched operands.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d        = bus.op_a;
          b_d        = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d    = bus.sub | bus.cin;
          idx_d      = '0;
          cout_d     = 1'b0;
          overflow_d = 1'b0;
          add_a_d    = bus.op_a[3:0];
          add_b_d    = b_d[3:0];
          add_cin_d  = carry_d;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_CAPT;
      end

      S_CAPT: begin
        result_d[{idx_q, 2'b00} +: 4] = bus.add_q[3:0];
        carry_d                       = bus.add_q[4];
        if (idx_q == LAST_IDX) begin
          cout_d     = bus.add_q[4];
          // carry into the MSB equals a^b^sum at that bit
          overflow_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ bus.add_q[3] ^ bus.add_q[4];
          state_d    = S_DONE;
        end else begin
          idx_d     = idx_q + IW'(1);
          add_a_d   = a_q[{idx_d, 2'b00} +: 4];
          add_b_d   = b_q[{idx_d, 2'b00} +: 4];
          add_cin_d = bus.add_q[4];
          state_d   = S_ISSUE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q == S_ISSUE) || (state_q == S_CAPT);
  assign bus.done     = (state_q == S_DONE);
  assign bus.add_en   = (state_q == S_ISSUE);
  assign bus.add_a    = add_a_q;
  assign bus.add_b    = add_b_q;
  assign bus.add_cin  = add_cin_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench for cla_nibble_sequencer at WIDTH=16 with a behavioural
// registered 5-bit adder standing in for the CLA slice.
module tb_cla_nibble_sequencer;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic [31:0] t0;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [4:0] slice_q = '0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned done_cnt = 0;
  int unsigned nib = 0;
  exp_t exp_q[$];

  cla_nibble_sequencer_if #(.WIDTH(W)) bus ();

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.add_en) slice_q <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
  assign bus.add_q = slice_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: whole-word arithmetic with signed range check for overflow.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c);
    exp_t e;
    int unsigned ua, ub, ur;
    int sa, sb, sr;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (s) begin
      ur = ua + 65536 - ub;
      e.co = (ua >= ub);
      sr = sa - sb;
      e.b = ~b;
      e.c0 = 1'b1;
    end else begin
      ur = ua + ub + c;
      e.co = (ur > 65535);
      sr = sa + sb + int'(c);
      e.b = b;
      e.c0 = c;
    end
    e.res = ur[15:0];
    e.ov = (sr > 32767) || (sr < -32768);
    e.a = a;
    e.t0 = 0;
    return e;
  endfunction

  exp_t mf;
  int unsigned mmask, mci;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.add_en) begin
        if (exp_q.size() == 0) chk("unexpected_add_en", 1, 0);
        else begin
          mf = exp_q[0];
          mmask = (32'd1 << (4 * nib)) - 1;
          mci = ((({16'b0, mf.a} & mmask) + ({16'b0, mf.b} & mmask) + mf.c0) >> (4 * nib)) & 1;
          chk("add_a", {28'b0, bus.add_a}, ({16'b0, mf.a} >> (4 * nib)) & 32'hF);
          chk("add_b", {28'b0, bus.add_b}, ({16'b0, mf.b} >> (4 * nib)) & 32'hF);
          chk("add_cin", {31'b0, bus.add_cin}, mci);
          chk("busy_in_issue", {31'b0, bus.busy}, 1);
          nib++;
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mf = exp_q.pop_front();
          chk("result", {16'b0, bus.result}, {16'b0, mf.res});
          chk("cout", {31'b0, bus.cout}, {31'b0, mf.co});
          chk("overflow", {31'b0, bus.overflow}, {31'b0, mf.ov});
          chk("latency", cyc - mf.t0, 8);
          chk("busy_in_done", {31'b0, bus.busy}, 0);
          chk("passes", nib, 4);
        end
        nib = 0;
        done_cnt++;
      end
    end
  end

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    exp_t e;
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
    e = model(a, b, s, c);
    @(posedge clk);
    #1;
    e.t0 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty();
    int unsigned k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 1, 0);
      exp_q.delete();
      nib = 0;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    launch(a, b, s, c);
    bus.start = 1'b0;
    bus.op_a = 16'($urandom);
    bus.op_b = 16'($urandom);
    bus.cin = 1'($urandom);
    wait_empty();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 0);
    chk({tag, "_done"}, {31'b0, bus.done}, 0);
    chk({tag, "_add_en"}, {31'b0, bus.add_en}, 0);
    chk({tag, "_add_cin"}, {31'b0, bus.add_cin}, 0);
    chk({tag, "_cout"}, {31'b0, bus.cout}, 0);
    chk({tag, "_overflow"}, {31'b0, bus.overflow}, 0);
    chk({tag, "_result"}, {16'b0, bus.result}, 0);
    chk({tag, "_add_ab"}, {24'b0, bus.add_a, bus.add_b}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned saved;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    chk("t1_result", {16'b0, bus.result}, 32'h2233);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t2_result", {16'b0, bus.result}, 32'h0000);
    chk("t2_cout", {31'b0, bus.cout}, 1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("t3_overflow", {31'b0, bus.overflow}, 1);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("t3_cin_result", {16'b0, bus.result}, 32'h0001);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    chk("t4_result", {16'b0, bus.result}, 32'hFFFE);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    chk("t4_result2", {16'b0, bus.result}, 32'h7FFF);
    run_op(16'hA5A5, 16'hA5A5, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b1);

    // start held across the whole op while operands keep changing
    saved = done_cnt;
    launch(16'h4321, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) break;
      bus.op_a = 16'($urandom);
      bus.op_b = 16'($urandom);
      bus.sub = 1'($urandom);
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_single_done", done_cnt - saved, 1);
    chk("t5_result", {16'b0, bus.result}, 32'h5432);
    wait_empty();

    // reset during the second CAPT pass aborts without done
    saved = done_cnt;
    launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_abort");
    exp_q.delete();
    nib = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", done_cnt - saved, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("t6_result", {16'b0, bus.result}, 32'h0002);

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
